response_router: RTL and testbench
==================================

# response_router

Parametrised successor to the single-output response control stage. It accepts CAPI PSL responses, checks tag parity and tags each response with its originating command class. Each response is steered, after a programmable delay, into one of NUM_CH per-class FIFOs with valid/ready drain handshakes. It sits between the PSL response interface and the AFU read/write/WED/restart engines, and reports sticky error status to the MMIO error register.

## Interface
- NUM_CH, 4, number of output channels (command classes), 2..8
- FIFO_DEPTH, 8, entries per channel FIFO, power of two, ≥2
- RSP_DELAY, 1, extra pipeline stages before enqueue, ≥1 (keeps responses behind their data)
- CH_W, $clog2(NUM_CH), channel index width
- clock  in  1  single clock for the whole block
- rstn  in  1  reset, synchronous and active-low
- enabled_in  in  1  block enable, registered internally (1-cycle effect delay)
- rsp_valid_in  in  1  PSL response valid
- rsp_tag_in  in  8  PSL response tag
- rsp_tag_parity_in  in  1  odd parity over rsp_tag_in
- rsp_code_in  in  8  PSL response code; 0x00 = DONE
- rsp_ch_in  in  CH_W  channel/class of the tag, from the tag table, same cycle as rsp_valid_in
- out_valid  out  NUM_CH  per-channel head-of-FIFO valid
- out_ready  in  NUM_CH  per-channel consumer ready
- out_tag  out  NUM_CH*8  per-channel head tag; channel k occupies bits [8k+7:8k]
- out_code  out  NUM_CH*8  per-channel head response code, same packing as out_tag
- out_perr  out  NUM_CH  per-channel head entry parity-error flag
- fifo_full  out  NUM_CH  per-channel FIFO full
- error_clear  in  1  single-cycle pulse; clears error_status and drop_count
- error_status  out  4  sticky {fail_code, overflow, bad_channel, tag_parity}, bit 0 = tag_parity
- drop_count  out  16  saturating count of dropped responses

## Operation
- All state changes on posedge clock. When rstn=0 at an edge, all pipeline registers, FIFO pointers, error_status and drop_count clear. Every output then reads 0 from the following cycle, and fifo_full reads 0.
- S0 (input latch): captures tag, parity, code and channel when enabled && rsp_valid_in; otherwise S0.valid←0.
- S1 (check): computes parity_err = ~(^tag ^ parity), i.e. the tag+parity bits do not have odd weight. Also computes bad_ch = (ch ≥ NUM_CH) and fail = (code ≠ 0x00). The entry is registered with these flags.
- D[1..RSP_DELAY]: shift register of S1 entries. Every stage clears when enabled=0.
- Enqueue, at the tail of D[RSP_DELAY]:
  - bad_ch: dropped, drop_count+1.
  - Target FIFO full and not dequeuing this cycle: dropped, overflow flag set, drop_count+1. CAPI responses cannot be back-pressured.
  - Otherwise: written with {tag, code, parity_err}.
  - Parity-error and failed-code entries are still enqueued (consumers retry/restart); the corresponding flags are set.
- FIFOs are first-word-fall-through: out_valid[k] = (count[k]≠0), and the head fields are valid whenever out_valid[k]=1. Dequeue on out_valid[k] && out_ready[k].
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits. fifo_full[k] = (count[k]==FIFO_DEPTH).
- Disable (enabled=0): the pipeline flushes; in-flight entries are lost and not counted. FIFO contents are retained and keep draining.
- error_status bits are OR-accumulated; drop_count saturates at 0xFFFF.
- If error_clear and a new error event occur on the same edge, the new event wins: the bit ends at 1 and drop_count ends at 1.

## Timing
- Latency: a response valid in cycle t on an enabled block with an empty target FIFO gives out_valid in cycle t+2+RSP_DELAY.
- error_status tag_parity/bad_channel/fail_code bits are visible in cycle t+2. The overflow bit and drop_count are visible in cycle t+2+RSP_DELAY.
- Throughput: one response per cycle sustained. Each channel drains one entry per cycle.
- Full FIFO with simultaneous enqueue and dequeue on the same edge: both occur, count unchanged, no overflow.
- Reset or disable mid-stream: no partial entry is ever enqueued.
- Effect delays after the edge at which the input changes:
  - enabled_in rising: responses are accepted from the second cycle.
  - enabled_in falling: responses stop being accepted from the second cycle.

## Test plan
- Single response, NUM_CH=4, RSP_DELAY=1: tag 0x15, parity 0, code 0x00, ch 2 at cycle 0. Expect out_valid[2]=1 in cycle 3 with out_tag 0x15, out_perr 0, error_status 0.
- Parity error: tag 0x15, parity 1. Expect error_status=4'b0001 at cycle 2, entry delivered with out_perr=1. Then error_clear → error_status 0.
- Overflow, FIFO_DEPTH=8: 10 back-to-back responses to ch 0 with out_ready[0]=0. Expect fifo_full[0]=1, 8 entries in order, drop_count=2, overflow bit set.
- Full plus simultaneous dequeue: ch 1 full, out_ready[1]=1 while one response arrives. Expect count stays 8, no overflow, drop_count unchanged.
- Bad channel and fail code:
  - ch=5 with NUM_CH=4: dropped, bad_channel bit set, drop_count 1.
  - code 0x01 to ch 3: delivered, fail_code bit set.
- Reset mid-stream: synchronous rstn=0 for 1 cycle with 3 responses in flight and 2 queued. Expect all out_valid=0, error_status 0, drop_count 0 next cycle, and no stray output afterwards.

Source files
------------

// File: rtl/response_router_if.sv
// Bundle between the PSL response side, the router and the per-class consumers.
// Each out channel k is valid/ready: an entry moves on a clock edge where out_valid[k] && out_ready[k].
interface response_router_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic                rsp_valid_in;
  logic [7:0]          rsp_tag_in;
  logic                rsp_tag_parity_in;
  logic [7:0]          rsp_code_in;
  logic [CH_W-1:0]     rsp_ch_in;

  logic [NUM_CH-1:0]   out_valid;
  logic [NUM_CH-1:0]   out_ready;
  logic [NUM_CH*8-1:0] out_tag;
  logic [NUM_CH*8-1:0] out_code;
  logic [NUM_CH-1:0]   out_perr;
  logic [NUM_CH-1:0]   fifo_full;

  modport master (
    output rsp_valid_in, rsp_tag_in, rsp_tag_parity_in, rsp_code_in, rsp_ch_in, out_ready,
    input  out_valid, out_tag, out_code, out_perr, fifo_full
  );

  modport slave (
    input  rsp_valid_in, rsp_tag_in, rsp_tag_parity_in, rsp_code_in, rsp_ch_in, out_ready,
    output out_valid, out_tag, out_code, out_perr, fifo_full
  );
endinterface

// File: rtl/response_router.sv
// Checks PSL response tag parity and steers each response, after a fixed delay,
// into a per-command-class first-word-fall-through FIFO; keeps sticky error status.
module response_router #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int RSP_DELAY  = 1,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic                enabled_in,
  input  logic                error_clear,
  output logic [3:0]          error_status,
  output logic [15:0]         drop_count,
  response_router_if.slave    bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic            valid;
    logic [7:0]      tag;
    logic            parity;
    logic [7:0]      code;
    logic [CH_W-1:0] ch;
  } s0_t;

  typedef struct packed {
    logic            valid;
    logic [7:0]      tag;
    logic [7:0]      code;
    logic            perr;
    logic            bad;
    logic            fail;
    logic [CH_W-1:0] ch;
  } ent_t;

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] code;
    logic       perr;
  } fifo_t;

  logic          en_q;
  s0_t           s0;
  ent_t          s1_next;
  ent_t          pipe [RSP_DELAY];
  ent_t          tail;
  logic [31:0]   ch_ext;

  fifo_t         mem  [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0] wptr [NUM_CH];
  logic [PW-1:0] rptr [NUM_CH];
  logic [CW-1:0] cnt  [NUM_CH];

  logic [NUM_CH-1:0]   vld;
  logic [NUM_CH-1:0]   full_w;
  logic [NUM_CH-1:0]   deq;
  logic [NUM_CH-1:0]   sel;
  logic [NUM_CH-1:0]   wr;
  logic [NUM_CH-1:0]   perr_w;
  logic [NUM_CH*8-1:0] tag_w;
  logic [NUM_CH*8-1:0] code_w;
  logic                tail_ok;
  logic                ovf;
  logic                drop_ev;
  logic [3:0]          err_set;
  logic [15:0]         drop_base;
  logic [15:0]         drop_next;

  // Check stage: flags are computed from S0 and registered into S1 and error_status together.
  always_comb begin
    s1_next        = '0;
    ch_ext         = '0;
    ch_ext[CH_W-1:0] = s0.ch;
    s1_next.valid  = s0.valid && en_q;
    s1_next.tag    = s0.tag;
    s1_next.code   = s0.code;
    s1_next.ch     = s0.ch;
    s1_next.perr   = ~(^s0.tag ^ s0.parity);
    s1_next.bad    = (ch_ext >= 32'(NUM_CH));
    s1_next.fail   = (s0.code != 8'h00);
  end

  assign tail = pipe[RSP_DELAY-1];

  // Enqueue decision and FWFT head presentation; heads read 0 while a FIFO is empty.
  always_comb begin
    vld     = '0;
    full_w  = '0;
    deq     = '0;
    sel     = '0;
    wr      = '0;
    perr_w  = '0;
    tag_w   = '0;
    code_w  = '0;
    ovf     = 1'b0;
    tail_ok = tail.valid && en_q;
    for (int k = 0; k < NUM_CH; k++) begin
      vld[k]    = (cnt[k] != '0);
      full_w[k] = (cnt[k] == CW'(FIFO_DEPTH));
      deq[k]    = vld[k] && bus.out_ready[k];
      sel[k]    = tail_ok && !tail.bad && (tail.ch == CH_W'(k));
      if (sel[k]) begin
        if (full_w[k] && !deq[k]) ovf = 1'b1;
        else                      wr[k] = 1'b1;
      end
      if (vld[k]) begin
        tag_w[8*k +: 8]  = mem[k][rptr[k]].tag;
        code_w[8*k +: 8] = mem[k][rptr[k]].code;
        perr_w[k]        = mem[k][rptr[k]].perr;
      end
    end
    drop_ev   = (tail_ok && tail.bad) || ovf;
    // Bit order: {fail_code, overflow, bad_channel, tag_parity}.
    err_set   = {s1_next.valid && s1_next.fail, ovf,
                 s1_next.valid && s1_next.bad, s1_next.valid && s1_next.perr};
    drop_base = error_clear ? 16'h0000 : drop_count;
    drop_next = (drop_ev && drop_base != 16'hFFFF) ? drop_base + 16'h0001 : drop_base;
  end

  assign bus.out_valid = vld;
  assign bus.fifo_full = full_w;
  assign bus.out_tag   = tag_w;
  assign bus.out_code  = code_w;
  assign bus.out_perr  = perr_w;

  always_ff @(posedge clock) begin
    if (!rstn) begin
      en_q         <= 1'b0;
      s0           <= '0;
      pipe         <= '{default: '0};
      wptr         <= '{default: '0};
      rptr         <= '{default: '0};
      cnt          <= '{default: '0};
      error_status <= 4'h0;
      drop_count   <= 16'h0000;
    end else begin
      en_q <= enabled_in;
      if (en_q && bus.rsp_valid_in) begin
        s0 <= '{valid: 1'b1, tag: bus.rsp_tag_in, parity: bus.rsp_tag_parity_in,
                code: bus.rsp_code_in, ch: bus.rsp_ch_in};
      end else begin
        s0.valid <= 1'b0;
      end
      // Disabling flushes the whole delay line; only FIFO contents survive.
      pipe[0] <= en_q ? s1_next : '0;
      for (int i = 1; i < RSP_DELAY; i++) begin
        pipe[i] <= en_q ? pipe[i-1] : '0;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr[k])  wptr[k] <= wptr[k] + 1'b1;
        if (deq[k]) rptr[k] <= rptr[k] + 1'b1;
        cnt[k] <= cnt[k] + CW'(wr[k]) - CW'(deq[k]);
      end
      error_status <= (error_clear ? 4'h0 : error_status) | err_set;
      drop_count   <= drop_next;
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr[k]) mem[k][wptr[k]] <= '{tag: tail.tag, code: tail.code, perr: tail.perr};
    end
  end

endmodule

// File: tb/tb_response_router.sv
// Directed bench for response_router: NUM_CH=4, FIFO_DEPTH=8, RSP_DELAY=1,
// with a 3-bit channel field so out-of-range classes can be presented.
module tb_response_router;

  logic        clock;
  logic        rstn;
  logic        enabled_in;
  logic        error_clear;
  logic [3:0]  error_status;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  response_router_if #(.NUM_CH(4), .CH_W(3)) bus ();

  response_router #(.NUM_CH(4), .FIFO_DEPTH(8), .RSP_DELAY(1), .CH_W(3)) dut (
    .clock        (clock),
    .rstn         (rstn),
    .enabled_in   (enabled_in),
    .error_clear  (error_clear),
    .error_status (error_status),
    .drop_count   (drop_count),
    .bus          (bus)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] tag);
    return ~^tag;
  endfunction

  task automatic drive(input logic [7:0] tag, input logic par, input logic [7:0] code,
                       input logic [2:0] ch);
    bus.rsp_valid_in      = 1'b1;
    bus.rsp_tag_in        = tag;
    bus.rsp_tag_parity_in = par;
    bus.rsp_code_in       = code;
    bus.rsp_ch_in         = ch;
  endtask

  task automatic idle();
    bus.rsp_valid_in      = 1'b0;
    bus.rsp_tag_in        = 8'h00;
    bus.rsp_tag_parity_in = 1'b0;
    bus.rsp_code_in       = 8'h00;
    bus.rsp_ch_in         = 3'd0;
  endtask

  task automatic drain(input int k);
    bus.out_ready[k] = 1'b1;
    step();
    bus.out_ready = '0;
  endtask

  task automatic clear_errors();
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enabled_in = 1'b0; error_clear = 1'b0; bus.out_ready = '0;
    idle();
    step(); step();
    n_checks++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL reset_out_valid: got %h want 0", bus.out_valid); end
    n_checks++; if (bus.fifo_full !== 4'h0) begin n_fail++; $display("FAIL reset_fifo_full: got %h want 0", bus.fifo_full); end
    n_checks++; if (error_status !== 4'h0) begin n_fail++; $display("FAIL reset_error_status: got %h want 0", error_status); end
    n_checks++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset_drop_count: got %h want 0", drop_count); end
    n_checks++; if (bus.out_tag !== 32'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
    rstn = 1'b1; enabled_in = 1'b1;
    step(); step();
  endtask

  task automatic test_single();
    drive(8'h15, 1'b0, 8'h00, 3'd2);
    step(); idle();
    n_checks++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL single_c1_valid: got %h want 0", bus.out_valid); end
    step();
    n_checks++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL single_c2_valid: got %h want 0", bus.out_valid); end
    step();
    n_checks++; if (bus.out_valid !== 4'b0100) begin n_fail++; $display("FAIL single_c3_valid: got %h want 4", bus.out_valid); end
    n_checks++; if (bus.out_tag[23:16] !== 8'h15) begin n_fail++; $display("FAIL single_tag: got %h want 15", bus.out_tag[23:16]); end
    n_checks++; if (bus.out_perr[2] !== 1'b0) begin n_fail++; $display("FAIL single_perr: got %b want 0", bus.out_perr[2]); end
    n_checks++; if (error_status !== 4'h0) begin n_fail++; $display("FAIL single_err: got %h want 0", error_status); end
    drain(2);
    n_checks++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL single_drained: got %h want 0", bus.out_valid); end
  endtask

  task automatic test_parity();
    drive(8'h15, 1'b1, 8'h00, 3'd2);
    step(); idle();
    n_checks++; if (error_status !== 4'h0) begin n_fail++; $display("FAIL parity_c1_err: got %h want 0", error_status); end
    step();
    n_checks++; if (error_status !== 4'b0001) begin n_fail++; $display("FAIL parity_c2_err: got %h want 1", error_status); end
    step();
    n_checks++; if (bus.out_valid[2] !== 1'b1) begin n_fail++; $display("FAIL parity_valid: got %b want 1", bus.out_valid[2]); end
    n_checks++; if (bus.out_perr[2] !== 1'b1) begin n_fail++; $display("FAIL parity_perr: got %b want 1", bus.out_perr[2]); end
    drain(2);
    clear_errors();
    n_checks++; if (error_status !== 4'h0) begin n_fail++; $display("FAIL parity_clear: got %h want 0", error_status); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      drive(8'h20 + 8'(i), odd_par(8'h20 + 8'(i)), 8'h00, 3'd0);
      step();
    end
    idle();
    step(); step(); step();
    n_checks++; if (bus.fifo_full[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", bus.fifo_full[0]); end
    n_checks++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drops: got %0d want 2", drop_count); end
    n_checks++; if (error_status !== 4'b0100) begin n_fail++; $display("FAIL ovf_err: got %h want 4", error_status); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bus.out_valid[0] !== 1'b1 || bus.out_tag[7:0] !== 8'h20 + 8'(i)) begin
        n_fail++; $display("FAIL ovf_order[%0d]: got v=%b tag=%h want v=1 tag=%h", i, bus.out_valid[0], bus.out_tag[7:0], 8'h20 + 8'(i));
      end
      bus.out_ready[0] = 1'b1;
      step();
    end
    bus.out_ready = '0;
    n_checks++; if (bus.out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", bus.out_valid[0]); end
    n_checks++; if (bus.fifo_full[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_notfull: got %b want 0", bus.fifo_full[0]); end
    clear_errors();
    n_checks++; if (drop_count !== 16'd0 || error_status !== 4'h0) begin n_fail++; $display("FAIL ovf_clear: got drops=%0d err=%h want 0 0", drop_count, error_status); end
  endtask

  task automatic test_full_deq();
    for (int i = 0; i < 8; i++) begin
      drive(8'h40 + 8'(i), odd_par(8'h40 + 8'(i)), 8'h00, 3'd1);
      step();
    end
    idle();
    step(); step(); step();
    n_checks++; if (bus.fifo_full[1] !== 1'b1) begin n_fail++; $display("FAIL fdq_prefull: got %b want 1", bus.fifo_full[1]); end
    drive(8'h48, odd_par(8'h48), 8'h00, 3'd1);
    step(); idle();
    step();
    bus.out_ready[1] = 1'b1;
    step();
    bus.out_ready = '0;
    n_checks++; if (bus.fifo_full[1] !== 1'b1) begin n_fail++; $display("FAIL fdq_full: got %b want 1", bus.fifo_full[1]); end
    n_checks++; if (error_status !== 4'h0) begin n_fail++; $display("FAIL fdq_err: got %h want 0", error_status); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL fdq_drops: got %0d want 0", drop_count); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bus.out_valid[1] !== 1'b1 || bus.out_tag[15:8] !== 8'h41 + 8'(i)) begin
        n_fail++; $display("FAIL fdq_order[%0d]: got v=%b tag=%h want v=1 tag=%h", i, bus.out_valid[1], bus.out_tag[15:8], 8'h41 + 8'(i));
      end
      bus.out_ready[1] = 1'b1;
      step();
    end
    bus.out_ready = '0;
    n_checks++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL fdq_empty: got %h want 0", bus.out_valid); end
  endtask

  task automatic test_bad_fail();
    drive(8'h01, 1'b0, 8'h00, 3'd5);
    step(); idle();
    step();
    n_checks++; if (error_status !== 4'b0010) begin n_fail++; $display("FAIL bad_err: got %h want 2", error_status); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL bad_drop_early: got %0d want 0", drop_count); end
    step();
    n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL bad_drop: got %0d want 1", drop_count); end
    step();
    n_checks++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL bad_no_out: got %h want 0", bus.out_valid); end
    // Clear lands on the same edge that raises bad_channel again.
    drive(8'h01, 1'b0, 8'h00, 3'd5);
    step(); idle();
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
    n_checks++; if (error_status !== 4'b0010) begin n_fail++; $display("FAIL clr_race_err: got %h want 2", error_status); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL clr_race_drop0: got %0d want 0", drop_count); end
    step();
    n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL clr_race_drop1: got %0d want 1", drop_count); end
    clear_errors();
    drive(8'h03, 1'b1, 8'h01, 3'd3);
    step(); idle();
    step();
    n_checks++; if (error_status !== 4'b1000) begin n_fail++; $display("FAIL fail_err: got %h want 8", error_status); end
    step();
    n_checks++; if (bus.out_valid !== 4'b1000) begin n_fail++; $display("FAIL fail_valid: got %h want 8", bus.out_valid); end
    n_checks++; if (bus.out_code[31:24] !== 8'h01) begin n_fail++; $display("FAIL fail_code: got %h want 01", bus.out_code[31:24]); end
    n_checks++; if (bus.out_tag[31:24] !== 8'h03) begin n_fail++; $display("FAIL fail_tag: got %h want 03", bus.out_tag[31:24]); end
    drain(3);
    clear_errors();
  endtask

  task automatic test_disable();
    drive(8'h11, 1'b1, 8'h00, 3'd0);
    step(); idle();
    enabled_in = 1'b0;
    step(); step(); step();
    n_checks++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL dis_flushed: got %h want 0", bus.out_valid); end
    enabled_in = 1'b1;
    step(); step();
    drive(8'h12, 1'b1, 8'h00, 3'd0);
    step(); idle();
    step(); step();
    n_checks++; if (bus.out_valid !== 4'b0001 || bus.out_tag[7:0] !== 8'h12) begin
      n_fail++; $display("FAIL dis_reenable: got v=%h tag=%h want v=1 tag=12", bus.out_valid, bus.out_tag[7:0]);
    end
    drain(0);
  endtask

  task automatic test_reset_mid();
    drive(8'h50, odd_par(8'h50), 8'h00, 3'd0); step();
    drive(8'h51, odd_par(8'h51), 8'h00, 3'd0); step();
    drive(8'h52, odd_par(8'h52), 8'h00, 3'd6); step();
    idle();
    step(); step(); step();
    n_checks++; if (bus.out_valid[0] !== 1'b1 || drop_count !== 16'd1) begin
      n_fail++; $display("FAIL rmid_pre: got v=%b drops=%0d want v=1 drops=1", bus.out_valid[0], drop_count);
    end
    drive(8'h60, odd_par(8'h60), 8'h00, 3'd1); step();
    drive(8'h61, odd_par(8'h61), 8'h00, 3'd1); step();
    drive(8'h62, odd_par(8'h62), 8'h00, 3'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    idle();
    n_checks++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL rmid_valid: got %h want 0", bus.out_valid); end
    n_checks++; if (error_status !== 4'h0) begin n_fail++; $display("FAIL rmid_err: got %h want 0", error_status); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rmid_drops: got %0d want 0", drop_count); end
    n_checks++; if (bus.out_tag !== 32'h0) begin n_fail++; $display("FAIL rmid_tag: got %h want 0", bus.out_tag); end
    step(); step(); step(); step(); step();
    n_checks++; if (bus.out_valid !== 4'h0) begin n_fail++; $display("FAIL rmid_stray: got %h want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_overflow();
    test_full_deq();
    test_bad_fail();
    test_disable();
    test_reset_mid();
    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
